// File: rtl/f_pc.sv
// Fetch-stage program counter. It picks the next PC from the D-stage redirect,
// checks it against the instruction-memory window, and halts fetch on an illegal target.
module f_pc #(
    parameter logic [31:0] INIT_PC  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_en,
    input  logic [1:0]  D_npc_sel,
    input  logic        D_branch_taken,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs_data,
    output logic [31:0] F_PC,
    output logic        F_valid,
    output logic        F_halt,
    output logic [31:0] F_stall_cnt
);

    localparam logic [31:0] LAST_PC = INIT_PC + 32'(4 * IM_WORDS) - 32'd4;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic        r_halt;
    logic [31:0] r_stall;

    logic [31:0] w_seq;
    logic [31:0] w_dpc4;
    logic [31:0] w_br;
    logic [31:0] w_npc;
    logic        w_legal;

    assign w_seq  = r_pc + 32'd4;
    assign w_dpc4 = D_PC + 32'd4;
    assign w_br   = w_dpc4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};

    always_comb begin
        w_npc = w_seq;
        case (D_npc_sel)
            2'b00:   w_npc = w_seq;
            2'b01:   w_npc = D_branch_taken ? w_br : w_seq;
            2'b10:   w_npc = {w_dpc4[31:28], D_imm26, 2'b00};
            default: w_npc = D_rs_data;
        endcase
    end

    assign w_legal = (w_npc[1:0] == 2'b00) && (w_npc >= INIT_PC) && (w_npc <= LAST_PC);

    // D inputs only reach the PC through this register, never straight to the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_pc    <= INIT_PC;
            r_valid <= 1'b1;
            r_halt  <= 1'b0;
            r_stall <= 32'd0;
        end else if (r_state == S_RUN) begin
            if (F_en) begin
                if (w_legal) begin
                    r_pc <= w_npc;
                end else begin
                    r_state <= S_HALT;
                    r_valid <= 1'b0;
                    r_halt  <= 1'b1;
                end
            end else if (r_stall != 32'hFFFF_FFFF) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign F_PC        = r_pc;
    assign F_valid     = r_valid;
    assign F_halt      = r_halt;
    assign F_stall_cnt = r_stall;

endmodule

// File: doc/f_pc.md
F_PC -- requirements
Module: f_pc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter INIT_PC, default 32'h0000_3000, SHALL be the reset PC and the lowest legal fetch address.
REQ-003 Parameter IM_WORDS, default 4096, SHALL be the instruction-memory depth in words; the highest legal address is INIT_PC + 4*IM_WORDS - 4.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 F_en  in  1  fetch enable; 0 means stall (hold the PC).
REQ-007 D_npc_sel  in  2  next-PC source: 00 = sequential, 01 = branch, 10 = j/jal, 11 = jr.
REQ-008 D_branch_taken  in  1  branch compare result from the D stage.
REQ-009 D_PC  in  32  PC of the instruction in the D stage.
REQ-010 D_imm16  in  16  branch offset.
REQ-011 D_imm26  in  26  jump index.
REQ-012 D_rs_data  in  32  forwarded rs value, used for jr.
REQ-013 F_PC  out  32  current fetch address, driven to instruction memory.
REQ-014 F_valid  out  1  the fetched word is a legal instruction.
REQ-015 F_halt  out  1  fetch has stopped on an illegal next PC.
REQ-016 F_stall_cnt  out  32  count of stalled cycles while running.

Function
REQ-017 The block SHALL have two states, RUN and HALT; F_valid = (state==RUN) and F_halt = (state==HALT).
REQ-018 The candidate next PC (NPC) SHALL be computed combinationally as follows; all arithmetic is 32-bit modulo 2^32.
- sel 00: F_PC+4.
- sel 01 with D_branch_taken=1: D_PC+4+(sign_extend(D_imm16)<<2).
- sel 01 with D_branch_taken=0: F_PC+4.
- sel 10: {D_PC+4 [31:28], D_imm26, 2'b00}.
- sel 11: D_rs_data.
REQ-019 NPC SHALL be legal iff NPC[1:0]==0 and INIT_PC <= NPC <= the last legal address (unsigned compare).
REQ-020 In RUN with F_en=1 and a legal NPC, F_PC SHALL load NPC on the next rising edge.
REQ-021 In RUN with F_en=1 and an illegal NPC, F_PC SHALL hold and state SHALL go to HALT on that edge.
REQ-022 With F_en=0, F_PC and state SHALL hold regardless of D_npc_sel; the redirect is honoured on the first edge with F_en=1, because the D stage holds its inputs during a stall.
REQ-023 HALT SHALL be sticky until reset, with F_PC frozen and F_en and the D inputs ignored.
REQ-024 F_stall_cnt SHALL increment by 1 on each edge in RUN with F_en=0, saturate at 32'hFFFF_FFFF, and hold in HALT.
REQ-025 Redirect latency SHALL be one cycle: the delay-slot instruction is the one at F_PC when the redirect is presented, and no flush is generated.
REQ-026 All outputs SHALL be registered-state functions only, with no combinational path from D inputs to F_PC.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for clk, set F_PC=INIT_PC, state=RUN, and F_stall_cnt=0.
REQ-028 After reset, F_valid=1 and F_halt=0.
REQ-029 Reset asserted mid-stall or in HALT SHALL behave identically to REQ-027, and it overrides F_en.
REQ-030 The first rising edge after reset deassertion SHALL follow REQ-020 to REQ-024 normally.

Verification
REQ-031 Sequential: reset, then F_en=1, sel=00 for 3 cycles -> F_PC steps 0x3000, 0x3004, 0x3008, 0x300C.
REQ-032 Branch: F_PC=0x3008, D_PC=0x3004, sel=01, taken=1, imm16=16'hFFFE -> F_PC becomes 0x3000. With taken=0, F_PC becomes 0x300C.
REQ-033 Jump and jr: D_PC=0x3010, sel=10, imm26=26'h0000C10 -> F_PC becomes 0x3040. sel=11, rs=0x3100 -> F_PC becomes 0x3100.
REQ-034 Stall with redirect: F_en=0 for 2 edges with sel=10 applied -> F_PC unchanged and F_stall_cnt=2. Then F_en=1 -> F_PC loads the jump target on the next edge.
REQ-035 Illegal NPC: sel=11 with rs=0x3002, or with rs=0x7000 -> F_PC holds, F_halt=1, F_valid=0. A later legal sel/F_en SHALL NOT change F_PC.
REQ-036 Async reset: assert reset between clock edges while in HALT with F_stall_cnt=5 -> F_PC=0x3000, F_halt=0, F_stall_cnt=0, all before the next edge.
